// File: rtl/wb_queue_if.sv
// Writeback queue bus bundle.
// Groups the ALU/LSU result handshakes, the register-file write port, the decode
// forwarding lookups and the occupancy status into one interface.
//   slave  : the queue itself (consumes results, drives RF write and forwarding)
//   master : the environment (execute/memory stages, decode, register file)
// Handshake rule for both result channels: a result transfers on a rising clock
// edge where valid && ready; ready may depend combinationally on alu_valid (LSU
// side only) but valid never depends on ready.
interface wb_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            rf_we;
    logic [4:0]      rf_wr_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            fwd1_hit;
    logic [XLEN-1:0] fwd1_data;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd2_data;
    logic [CW-1:0]   count;
    logic            empty;

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               rs1_addr, rs2_addr,
        output alu_ready, lsu_ready, rf_we, rf_wr_addr, rf_wr_data,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count, empty
    );

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
               rs1_addr, rs2_addr,
        input  alu_ready, lsu_ready, rf_we, rf_wr_addr, rf_wr_data,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count, empty
    );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: in-order buffer between the ALU/LSU result paths and the
// single write port of the integer register file.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset, discards every queued entry
//   bus    : wb_queue_if.slave -- ALU/LSU result handshakes (up to two
//            enqueues per cycle, ALU older), RF write port drained one entry per
//            cycle from the head, rs1/rs2 forwarding of the youngest queued value,
//            and count/empty status.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_queue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [4:0]      rd_q   [DEPTH];
    logic [4:0]      rd_d   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [CW-1:0]   free;
    logic            alu_push;
    logic            lsu_push;
    logic            pop;
    logic [PW-1:0]   wr_idx;
    logic [PW-1:0]   fwd_idx;

    // Free space comes from registered occupancy only, so a pop this cycle does
    // not make room for this cycle's enqueues. The rst_n term keeps both readies
    // low for the whole reset interval, not just after the first edge.
    always_comb begin
        free          = CW'(DEPTH) - count_q;
        bus.alu_ready = rst_n && (free >= CW'(1));
        bus.lsu_ready = rst_n && ((free >= CW'(2)) ||
                                  ((free >= CW'(1)) && !bus.alu_valid));
    end

    // Handshakes to x0 complete but leave the queue untouched.
    always_comb begin
        alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != 5'd0);
        lsu_push = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != 5'd0);
        pop      = (count_q != '0);
    end

    // Pushes only ever target slots that were free at the start of the cycle, so
    // they can never collide with the head slot being popped.
    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        wr_idx = wr_ptr_q;
        if (alu_push) begin
            rd_d[wr_idx]   = bus.alu_rd;
            data_d[wr_idx] = bus.alu_data;
            wr_idx         = wr_idx + PW'(1);
        end
        if (lsu_push) begin
            rd_d[wr_idx]   = bus.lsu_rd;
            data_d[wr_idx] = bus.lsu_data;
            wr_idx         = wr_idx + PW'(1);
        end
        wr_ptr_d = wr_idx;
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(alu_push) + CW'(lsu_push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_q     <= rd_d;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Drain: the head is presented every non-empty cycle and popped on the same
    // edge the register file captures it.
    always_comb begin
        bus.count      = count_q;
        bus.empty      = (count_q == '0);
        bus.rf_we      = !bus.empty;
        bus.rf_wr_addr = bus.empty ? 5'd0 : rd_q[rd_ptr_q];
        bus.rf_wr_data = bus.empty ? '0   : data_q[rd_ptr_q];
    end

    // Forwarding walks the live entries from oldest to youngest; a later match
    // overrides an earlier one, so the youngest value wins. The head being
    // written this cycle is still live and still forwards.
    always_comb begin
        bus.fwd1_hit  = 1'b0;
        bus.fwd1_data = '0;
        bus.fwd2_hit  = 1'b0;
        bus.fwd2_data = '0;
        fwd_idx       = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if ((bus.rs1_addr != 5'd0) && (rd_q[fwd_idx] == bus.rs1_addr)) begin
                    bus.fwd1_hit  = 1'b1;
                    bus.fwd1_data = data_q[fwd_idx];
                end
                if ((bus.rs2_addr != 5'd0) && (rd_q[fwd_idx] == bus.rs2_addr)) begin
                    bus.fwd2_hit  = 1'b1;
                    bus.fwd2_data = data_q[fwd_idx];
                end
            end
        end
    end
endmodule
